// File: rtl/osc_pkg.sv
// osc_pkg: shared constants, segment encoding and digit tables for the
// oscilloscope timebase controller and its on-screen label.
package osc_pkg;

  localparam int unsigned TB_W    = 3;
  localparam int unsigned COORD_W = 12;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_N   = 7;

  // Label placement in screen coordinates
  localparam logic [COORD_W-1:0] LBL_ROW_TOP = 12'd940;
  localparam logic [COORD_W-1:0] LBL_ROW_MID = 12'd945;
  localparam logic [COORD_W-1:0] LBL_ROW_BOT = 12'd950;
  localparam logic [COORD_W-1:0] LBL_ROW_S   = 12'd944;
  localparam logic [COORD_W-1:0] LBL_X_D0    = 12'd243;
  localparam logic [COORD_W-1:0] LBL_X_D1    = 12'd253;
  localparam logic [COORD_W-1:0] LBL_X_DOT   = 12'd250;
  localparam logic [COORD_W-1:0] LBL_X_S     = 12'd261;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] hi;
    logic [DIGIT_W-1:0] lo;
  } digit_pair_t;

  // Digit to segment mask, bit position = seg_e value (gfedcba).
  // The one is drawn on the left strokes so it hugs the cell origin.
  function automatic logic [SEG_N-1:0] digit_segs(input logic [DIGIT_W-1:0] d);
    unique case (d)
      4'd0:    digit_segs = 7'b0111111;
      4'd1:    digit_segs = 7'b0110000;
      4'd2:    digit_segs = 7'b1011011;
      4'd3:    digit_segs = 7'b1001111;
      4'd4:    digit_segs = 7'b1100110;
      4'd5:    digit_segs = 7'b1101101;
      4'd6:    digit_segs = 7'b1111101;
      4'd7:    digit_segs = 7'b0000111;
      4'd8:    digit_segs = 7'b1111111;
      4'd9:    digit_segs = 7'b1101111;
      default: digit_segs = 7'b0000000;
    endcase
  endfunction

  // Timebase index to the two label digits ("hi.lo s")
  function automatic digit_pair_t index_digits(input logic [TB_W-1:0] idx);
    unique case (idx)
      3'd0:    index_digits = '{hi: 4'd0, lo: 4'd1};
      3'd1:    index_digits = '{hi: 4'd0, lo: 4'd2};
      3'd2:    index_digits = '{hi: 4'd0, lo: 4'd4};
      3'd3:    index_digits = '{hi: 4'd0, lo: 4'd8};
      3'd4:    index_digits = '{hi: 4'd1, lo: 4'd6};
      3'd5:    index_digits = '{hi: 4'd3, lo: 4'd2};
      default: index_digits = '{hi: 4'd0, lo: 4'd0};
    endcase
  endfunction

endpackage

// File: rtl/glyph_digit.sv
// glyph_digit: combinational seven-segment glyph on a 5x11 cell.
// Ports: horz/vert = pixel coordinate, x0 = cell left column,
//        digit = 0..9, pixel = 1 when the coordinate lies on a lit stroke.
module glyph_digit
  import osc_pkg::*;
(
  input  logic [COORD_W-1:0] horz,
  input  logic [COORD_W-1:0] vert,
  input  logic [COORD_W-1:0] x0,
  input  logic [DIGIT_W-1:0] digit,
  output logic               pixel
);

  logic [SEG_N-1:0]   segs;
  logic [COORD_W-1:0] x_right;
  logic               col_l;
  logic               col_r;
  logic               span;
  logic               upper;
  logic               lower;

  always_comb begin
    segs    = digit_segs(digit);
    x_right = x0 + COORD_W'(4);
    col_l   = (horz == x0);
    col_r   = (horz == x_right);
    span    = (horz >= x0) && (horz <= x_right);
    upper   = (vert >= LBL_ROW_TOP) && (vert <= LBL_ROW_MID);
    lower   = (vert >= LBL_ROW_MID) && (vert <= LBL_ROW_BOT);
    pixel   = (segs[SEG_A] && span  && (vert == LBL_ROW_TOP)) ||
              (segs[SEG_G] && span  && (vert == LBL_ROW_MID)) ||
              (segs[SEG_D] && span  && (vert == LBL_ROW_BOT)) ||
              (segs[SEG_F] && col_l && upper) ||
              (segs[SEG_E] && col_l && lower) ||
              (segs[SEG_B] && col_r && upper) ||
              (segs[SEG_C] && col_r && lower);
  end

endmodule

// File: rtl/timebase_ctrl.sv
// timebase_ctrl: steps the scope timebase on button presses, committing
// changes only at the frame boundary; drives the sample strobe and label.
// Ports: CLK, RESET (sync, active-high), BTN_UP/BTN_DOWN debounced levels,
//        VGA_horzCoord/VGA_vertCoord pixel position, TB_INDEX committed
//        index, SAMPLE_EN sample strobe, TB_CHANGED post-commit pulse,
//        LABEL_PIXEL registered label pixel.
module timebase_ctrl
  import osc_pkg::*;
#(
  parameter int unsigned BASE_DIV      = 1000,
  parameter int unsigned N_SETTINGS    = 6,
  parameter int unsigned RESET_INDEX   = 2,
  parameter int unsigned V_COMMIT_LINE = 1024
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BTN_UP,
  input  logic               BTN_DOWN,
  input  logic [COORD_W-1:0] VGA_horzCoord,
  input  logic [COORD_W-1:0] VGA_vertCoord,
  output logic [TB_W-1:0]    TB_INDEX,
  output logic               SAMPLE_EN,
  output logic               TB_CHANGED,
  output logic               LABEL_PIXEL
);

  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PEND_UP   = 2'd1;
  localparam logic [1:0] ST_PEND_DOWN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             btn_up_q, btn_dn_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TB_W-1:0]  idx_d;
  logic             changed_d;
  logic             sample_d;
  logic             up_edge_c, dn_edge_c, commit_c;
  logic [CNT_W-1:0] term_c;

  digit_pair_t        digits;
  logic               d0_pix, d1_pix;
  logic               dot_c, s_c, label_d;
  logic [3:0]         s_row;
  logic [COORD_W-1:0] s_dx;

  // Request FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, index step and sample divider
  always_comb begin
    up_edge_c = BTN_UP && !btn_up_q;
    dn_edge_c = BTN_DOWN && !btn_dn_q;
    commit_c  = (VGA_vertCoord == COORD_W'(V_COMMIT_LINE)) && (VGA_horzCoord == '0);
    term_c    = (CNT_W'(BASE_DIV) << TB_INDEX) - CNT_W'(1);

    state_d   = state_q;
    idx_d     = TB_INDEX;
    changed_d = 1'b0;
    cnt_d     = cnt_q + CNT_W'(1);
    sample_d  = 1'b0;

    if (commit_c) begin
      state_d = ST_IDLE;
      if (state_q == ST_PEND_UP && TB_INDEX != TB_W'(N_SETTINGS - 1)) begin
        idx_d     = TB_INDEX + TB_W'(1);
        changed_d = 1'b1;
      end else if (state_q == ST_PEND_DOWN && TB_INDEX != '0) begin
        idx_d     = TB_INDEX - TB_W'(1);
        changed_d = 1'b1;
      end
    end

    // A fresh edge (even in the commit cycle) becomes the pending request;
    // simultaneous edges cancel out.
    if (up_edge_c && !dn_edge_c)      state_d = ST_PEND_UP;
    else if (dn_edge_c && !up_edge_c) state_d = ST_PEND_DOWN;

    if (changed_d) begin
      cnt_d = '0;
    end else if (cnt_q == term_c) begin
      cnt_d    = '0;
      sample_d = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_up_q    <= 1'b0;
      btn_dn_q    <= 1'b0;
      cnt_q       <= '0;
      TB_INDEX    <= TB_W'(RESET_INDEX);
      SAMPLE_EN   <= 1'b0;
      TB_CHANGED  <= 1'b0;
      LABEL_PIXEL <= 1'b0;
    end else begin
      btn_up_q    <= BTN_UP;
      btn_dn_q    <= BTN_DOWN;
      cnt_q       <= cnt_d;
      TB_INDEX    <= idx_d;
      SAMPLE_EN   <= sample_d;
      TB_CHANGED  <= changed_d;
      LABEL_PIXEL <= label_d;
    end
  end

  glyph_digit u_digit0 (
    .horz  (VGA_horzCoord),
    .vert  (VGA_vertCoord),
    .x0    (LBL_X_D0),
    .digit (digits.hi),
    .pixel (d0_pix)
  );

  glyph_digit u_digit1 (
    .horz  (VGA_horzCoord),
    .vert  (VGA_vertCoord),
    .x0    (LBL_X_D1),
    .digit (digits.lo),
    .pixel (d1_pix)
  );

  // Decimal point, "s" glyph (4-wide row masks, bit = column offset) and label merge
  always_comb begin
    digits = index_digits(TB_INDEX);
    dot_c  = (VGA_horzCoord == LBL_X_DOT) && (VGA_vertCoord == LBL_ROW_BOT);
    s_dx   = VGA_horzCoord - LBL_X_S;
    unique case (VGA_vertCoord)
      LBL_ROW_S:            s_row = 4'b0110;
      LBL_ROW_S + 12'd1:    s_row = 4'b1001;
      LBL_ROW_S + 12'd2:    s_row = 4'b0001;
      LBL_ROW_S + 12'd3:    s_row = 4'b0110;
      LBL_ROW_S + 12'd4:    s_row = 4'b1000;
      LBL_ROW_S + 12'd5:    s_row = 4'b1001;
      LBL_ROW_S + 12'd6:    s_row = 4'b0110;
      default:              s_row = 4'b0000;
    endcase
    s_c     = (VGA_horzCoord >= LBL_X_S) && (s_dx < COORD_W'(4)) && s_row[s_dx[1:0]];
    label_d = d0_pix || d1_pix || dot_c || s_c;
  end

endmodule
